// File: rtl/conf_loader.sv
// -----------------------------------------------------------------------------
// conf_loader
// Boot-time configuration sequencer for the um_for_cpu packet port. On start it
// emits three packets back to back (separated by idle gaps):
//   phase 0 : conf_sel = 1 select packet (holds the CPU)
//   phase 1 : program packet streaming PROG_WORDS firmware words from a ROM
//   phase 2 : conf_sel = 0 select packet (releases the CPU)
//
// Ports
//   clk        : sole clock
//   rst        : asynchronous active-high reset
//   start      : one-cycle request, honoured only while idle
//   busy       : high while a sequence is in progress
//   done       : one-cycle pulse after the final beat of the last packet
//   mem_rd     : ROM read strobe (one-cycle read latency)
//   mem_addr   : ROM word address
//   mem_rdata  : ROM read data, valid the cycle after mem_rd
//   pkt_ready  : downstream grant, sampled only while waiting to start a packet
//   pkt_valid  : beat valid
//   pkt_data   : beat {tag[1:0], 4'hf, payload[127:0]}
//
// All outputs are registered. Packet outputs reflect the state of the previous
// cycle, which lets a data beat capture the ROM word returned in its own state
// cycle while the ROM is already fetching the next word.
// -----------------------------------------------------------------------------
module conf_loader #(
   parameter int unsigned PROG_WORDS = 20000,
   parameter int unsigned GAP_CYCLES = 128
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   output logic         busy,
   output logic         done,
   output logic         mem_rd,
   output logic [15:0]  mem_addr,
   input  logic [31:0]  mem_rdata,
   input  logic         pkt_ready,
   output logic         pkt_valid,
   output logic [133:0] pkt_data
);

   localparam int unsigned CNT_W = 16;
   localparam int unsigned PAY_W = 128;
   localparam int unsigned PKT_W = 134;

   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] PROG_LAST = CNT_W'(PROG_WORDS - 1);

   localparam logic [1:0] TAG_HEAD = 2'b01;
   localparam logic [1:0] TAG_MID  = 2'b00;
   localparam logic [1:0] TAG_TAIL = 2'b10;
   localparam logic [3:0] PKT_FILL = 4'hf;

   localparam logic [PAY_W-1:0] HDR_SEL  = 128'h1111_2222_3333_4444_5555_6666_9001_0000;
   localparam logic [PAY_W-1:0] HDR_PROG = 128'h1111_2222_3333_4444_5555_6666_9003_0000;
   localparam logic [PAY_W-1:0] SEL_ON   = 128'h1_0000;

   typedef enum logic [3:0] {
      S_IDLE,
      S_GAP,
      S_WAIT_RDY,
      S_SEL_HDR,
      S_SEL_B1,
      S_SEL_B2,
      S_SEL_B3,
      S_PROG_HDR,
      S_PROG_DATA,
      S_DONE
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [1:0]         phase;
   logic [1:0]         phase_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;

   logic               busy_d;
   logic               done_d;
   logic               mem_rd_d;
   logic [CNT_W-1:0]   mem_addr_d;
   logic               pkt_valid_d;
   logic [PKT_W-1:0]   pkt_data_d;

   // State register with phase and shared gap/word counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         phase <= 2'd0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         phase <= phase_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic. cnt counts gap cycles in S_GAP and the word index in
   // S_PROG_DATA; it is zeroed on entry to either state.
   always_comb begin
      state_nxt = state;
      phase_nxt = phase;
      cnt_nxt   = cnt;
      unique case (state)
         S_IDLE: begin
            // done is still high in the first idle cycle; a start there is dropped
            if (start && !done) begin
               state_nxt = S_GAP;
               phase_nxt = 2'd0;
               cnt_nxt   = '0;
            end
         end
         S_GAP: begin
            if (cnt == GAP_LAST) begin
               state_nxt = S_WAIT_RDY;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_WAIT_RDY: begin
            if (pkt_ready) begin
               state_nxt = (phase == 2'd1) ? S_PROG_HDR : S_SEL_HDR;
            end
         end
         S_SEL_HDR: state_nxt = S_SEL_B1;
         S_SEL_B1:  state_nxt = S_SEL_B2;
         S_SEL_B2:  state_nxt = S_SEL_B3;
         S_SEL_B3: begin
            if (phase < 2'd2) begin
               phase_nxt = phase + 2'd1;
               state_nxt = S_GAP;
               cnt_nxt   = '0;
            end else begin
               state_nxt = S_DONE;
            end
         end
         S_PROG_HDR: begin
            state_nxt = S_PROG_DATA;
            cnt_nxt   = '0;
         end
         S_PROG_DATA: begin
            if (cnt == PROG_LAST) begin
               phase_nxt = phase + 2'd1;
               state_nxt = S_GAP;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output decode: packet beat for the current state, ROM read for the next.
   always_comb begin
      busy_d      = (state != S_IDLE) && (state != S_DONE);
      done_d      = (state == S_DONE);
      pkt_valid_d = 1'b0;
      pkt_data_d  = '0;
      mem_rd_d    = 1'b0;
      mem_addr_d  = mem_addr;

      unique case (state)
         S_SEL_HDR: begin
            pkt_valid_d = 1'b1;
            pkt_data_d  = {TAG_HEAD, PKT_FILL, HDR_SEL};
         end
         S_SEL_B1: begin
            pkt_valid_d = 1'b1;
            pkt_data_d  = {TAG_MID, PKT_FILL, (phase == 2'd0) ? SEL_ON : PAY_W'(0)};
         end
         S_SEL_B2: begin
            pkt_valid_d = 1'b1;
            pkt_data_d  = {TAG_MID, PKT_FILL, PAY_W'(0)};
         end
         S_SEL_B3: begin
            pkt_valid_d = 1'b1;
            pkt_data_d  = {TAG_TAIL, PKT_FILL, PAY_W'(0)};
         end
         S_PROG_HDR: begin
            pkt_valid_d = 1'b1;
            pkt_data_d  = {TAG_HEAD, PKT_FILL, HDR_PROG};
         end
         S_PROG_DATA: begin
            // mem_rdata here is the word fetched for index cnt
            pkt_valid_d = 1'b1;
            pkt_data_d  = {(cnt == PROG_LAST) ? TAG_TAIL : TAG_MID, PKT_FILL,
                           48'h0, mem_rdata, 16'h0, cnt, 16'h0};
         end
         default: begin
            pkt_valid_d = 1'b0;
         end
      endcase

      // Prefetch: word 0 during the program head, word i+1 during data beat i.
      if (state_nxt == S_PROG_HDR) begin
         mem_rd_d   = 1'b1;
         mem_addr_d = '0;
      end else if ((state_nxt == S_PROG_DATA) && (cnt_nxt != PROG_LAST)) begin
         mem_rd_d   = 1'b1;
         mem_addr_d = cnt_nxt + CNT_W'(1);
      end
   end

   // Output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_rd    <= 1'b0;
         mem_addr  <= '0;
         pkt_valid <= 1'b0;
         pkt_data  <= '0;
      end else begin
         busy      <= busy_d;
         done      <= done_d;
         mem_rd    <= mem_rd_d;
         mem_addr  <= mem_addr_d;
         pkt_valid <= pkt_valid_d;
         pkt_data  <= pkt_data_d;
      end
   end

endmodule

// File: tb/tb_conf_loader.sv
// -----------------------------------------------------------------------------
// tb_conf_loader
// Two loaders (4-word and 1-word programs) share start/ready/reset. A per-cycle
// behavioural model derives, from the packet rules, when each head must appear,
// the content of every beat, the ROM read schedule, busy and done.
// -----------------------------------------------------------------------------
module tb_conf_loader;

   localparam int unsigned P0 = 4;
   localparam int unsigned G0 = 4;
   localparam int unsigned P1 = 1;
   localparam int unsigned G1 = 2;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic ready;

   logic         busy0, done0, mrd0, v0;
   logic [15:0]  ma0;
   logic [31:0]  rd0;
   logic [133:0] d0;
   logic         busy1, done1, mrd1, v1;
   logic [15:0]  ma1;
   logic [31:0]  rd1;
   logic [133:0] d1;

   always #5 clk = ~clk;

   conf_loader #(.PROG_WORDS(P0), .GAP_CYCLES(G0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0),
      .mem_rd(mrd0), .mem_addr(ma0), .mem_rdata(rd0), .pkt_ready(ready),
      .pkt_valid(v0), .pkt_data(d0));

   conf_loader #(.PROG_WORDS(P1), .GAP_CYCLES(G1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1),
      .mem_rd(mrd1), .mem_addr(ma1), .mem_rdata(rd1), .pkt_ready(ready),
      .pkt_valid(v1), .pkt_data(d1));

   // ROM with one-cycle latency; junk when not read so stale data is visible.
   logic [31:0] rom [16];
   always @(posedge clk) begin
      rd0 <= mrd0 ? rom[ma0[3:0]] : $urandom;
      rd1 <= mrd1 ? rom[ma1[3:0]] : $urandom;
   end

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int vseen = 0;
   int mode  = 0;

   bit running [2];
   bit waiting [2];
   int gs      [2];
   int exp_head[2];
   int done_exp[2];
   int ph      [2];
   int k       [2];
   int rd_cnt  [2];
   int st_cyc  [2];
   int done_cyc[2];
   int heads   [2];
   logic [133:0] log0[$];

   task automatic cmp(input string name, input int id, input logic [133:0] act,
                      input logic [133:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d: got %h want %h (cycle %0d)", name, id, act, exp, cyc);
      end
   endtask

   function automatic logic [133:0] exp_beat(input int p, input int phs, input int kk);
      logic [127:0] pl;
      logic [1:0]   tag;
      if (phs == 1) begin
         if (kk == 0) return {2'b01, 4'hf, 128'h1111_2222_3333_4444_5555_6666_9003_0000};
         tag = (kk == p) ? 2'b10 : 2'b00;
         pl  = {48'h0, rom[kk-1], 16'h0, 16'(kk-1), 16'h0};
         return {tag, 4'hf, pl};
      end
      case (kk)
         0:       return {2'b01, 4'hf, 128'h1111_2222_3333_4444_5555_6666_9001_0000};
         1:       return {2'b00, 4'hf, (phs == 0) ? 128'h1_0000 : 128'h0};
         2:       return {2'b00, 4'hf, 128'h0};
         default: return {2'b10, 4'hf, 128'h0};
      endcase
   endfunction

   // Per-cycle check of one loader against the model.
   task automatic mon(input int id, input int p, input int g, input logic v,
                      input logic [133:0] d, input logic bz, input logic dn,
                      input logic mrd, input logic [15:0] ma);
      bit done_now;
      int plen;
      if (rst) begin
         cmp("rst_ctl", id, 134'({v, bz, dn, mrd, ma}), '0);
         cmp("rst_data", id, d, '0);
         running[id] = 0; waiting[id] = 0; exp_head[id] = -1; done_exp[id] = -1;
         ph[id] = 0; k[id] = 0; rd_cnt[id] = 0; heads[id] = 0;
         return;
      end
      done_now = (cyc == done_exp[id]);
      cmp("busy", id, 134'(bz), 134'(running[id] && (cyc > gs[id]) && !done_now));
      cmp("done", id, 134'(dn), 134'(done_now));
      if (done_now) begin
         cmp("rd_count", id, 134'(rd_cnt[id]), 134'(p));
         done_cyc[id] = cyc;
         running[id] = 0;
      end
      if (waiting[id] && (cyc >= gs[id] + g) && ready) begin
         exp_head[id] = cyc + 2;
         waiting[id]  = 0;
      end
      if (v) begin
         if (d[133:132] == 2'b01) heads[id]++;
         if (k[id] == 0) cmp("head_time", id, 134'(cyc), 134'(exp_head[id]));
         if (ph[id] > 2) begin
            cmp("extra_beat", id, 134'(ph[id]), 134'(2));
         end else begin
            cmp("beat", id, d, exp_beat(p, ph[id], k[id]));
            plen = (ph[id] == 1) ? p + 1 : 4;
            k[id]++;
            if (k[id] == plen) begin
               k[id] = 0;
               ph[id]++;
               if (ph[id] == 3) done_exp[id] = cyc + 1;
               else begin gs[id] = cyc; waiting[id] = 1; end
            end
         end
      end else begin
         if (k[id] != 0) cmp("bubble", id, 134'(v), 134'(1));
         if (cyc == exp_head[id]) cmp("head_missing", id, 134'(v), 134'(1));
      end
      if (mrd) begin
         cmp("mem_addr", id, 134'(ma), 134'(rd_cnt[id]));
         cmp("mem_rd_time", id, 134'(cyc),
             (ph[id] == 1 && rd_cnt[id] < p) ? 134'(exp_head[id] - 1 + rd_cnt[id]) : 134'(-1));
         rd_cnt[id]++;
      end
      if (!running[id] && start && !done_now) begin
         running[id] = 1; waiting[id] = 1; gs[id] = cyc + 1; st_cyc[id] = cyc;
         ph[id] = 0; k[id] = 0; rd_cnt[id] = 0; exp_head[id] = -1; done_exp[id] = -1;
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (v0 || v1) vseen++;
      if (v0 && !rst) log0.push_back(d0);
      mon(0, P0, G0, v0, d0, busy0, done0, mrd0, ma0);
      mon(1, P1, G1, v1, d1, busy1, done1, mrd1, ma1);
   end

   // Grant: always on, random, or withheld ~50 cycles into each wait of dut0.
   always @(posedge clk) begin
      #2;
      case (mode)
         0:       ready = 1'b1;
         1:       ready = ($urandom % 3) != 0;
         default: ready = (cyc + 1) >= (gs[0] + int'(G0) + 50);
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input bit extras);
      int n = 0;
      while ((running[0] || running[1]) && n < 5000) begin
         tick();
         n++;
         if (extras) start = (n == 10) || done0;
      end
      start = 1'b0;
      cmp("run_timeout", 0, 134'(running[0] || running[1]), '0);
   endtask

   task automatic rand_rom();
      for (int i = 0; i < 4; i++) rom[i] = $urandom;
   endtask

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; ready = 1'b1; mode = 0;
      for (int i = 0; i < 16; i++) rom[i] = '0;
      rom[0] = 32'h10000537; rom[1] = 32'h04400593;
      rom[2] = 32'h04f00613; rom[3] = 32'h04e00693;

      // start under reset must do nothing
      repeat (2) tick();
      pulse_start();
      repeat (2) tick();
      rst = 1'b0;
      vseen = 0;
      repeat (1000) tick();
      cmp("idle_no_valid", 0, 134'(vseen), '0);

      // reference load with extra starts during busy and on the done cycle
      log0.delete();
      heads[0] = 0;
      pulse_start();
      wait_idle(1'b1);
      cmp("heads_run1", 0, 134'(heads[0]), 134'(3));
      cmp("beats_run1", 0, 134'(log0.size()), 134'(13));
      cmp("latency_run1", 0, 134'(done_cyc[0] - st_cyc[0]), 134'(30));
      if (log0.size() == 13) begin
         cmp("lit_sel_head", 0, log0[0], {2'b01, 4'hf, 128'h1111_2222_3333_4444_5555_6666_9001_0000});
         cmp("lit_sel_b1_on", 0, log0[1], {2'b00, 4'hf, 128'h1_0000});
         cmp("lit_prog_head", 0, log0[4], {2'b01, 4'hf, 128'h1111_2222_3333_4444_5555_6666_9003_0000});
         cmp("lit_data0", 0, log0[5], {2'b00, 4'hf, 48'h0, 32'h10000537, 16'h0, 16'h0, 16'h0});
         cmp("lit_data3", 0, log0[8], {2'b10, 4'hf, 48'h0, 32'h04e00693, 16'h0, 16'h3, 16'h0});
         cmp("lit_sel_b1_off", 0, log0[10], {2'b00, 4'hf, 128'h0});
         cmp("lit_sel_tail", 0, log0[12], {2'b10, 4'hf, 128'h0});
      end

      // grant withheld in every wait
      rand_rom();
      mode = 2;
      heads[0] = 0;
      pulse_start();
      wait_idle(1'b0);
      cmp("heads_bp", 0, 134'(heads[0]), 134'(3));

      // random grant, random firmware
      mode = 1;
      for (int r = 0; r < 3; r++) begin
         rand_rom();
         heads[0] = 0;
         pulse_start();
         wait_idle(1'b0);
         cmp("heads_rand", 0, 134'(heads[0]), 134'(3));
      end

      // reset on the third program data beat, then a full reload
      mode = 0;
      rand_rom();
      pulse_start();
      n = 0;
      while (!(ph[0] == 1 && k[0] == 3) && n < 2000) begin
         tick();
         n++;
      end
      cmp("reach_data2", 0, 134'(ph[0] == 1 && k[0] == 3), 134'(1));
      cmp("data2_on_bus", 0, 134'(v0), 134'(1));
      rst = 1'b1;
      #1;
      cmp("rst_async", 0, 134'({v0, busy0, mrd0, d0 != 134'h0}), '0);
      tick();
      rst = 1'b0;
      tick();
      heads[0] = 0;
      pulse_start();
      wait_idle(1'b0);
      cmp("heads_after_rst", 0, 134'(heads[0]), 134'(3));

      repeat (5) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
